// File: rtl/program_memory_pkg.sv
// Shared processor definitions for the instruction store: FSM states and the default
// filler word returned for dropped fetches.
package program_memory_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } pm_state_e;

    // ADD reg0,reg0,reg0 encodes as all zeros
    localparam logic [31:0] PM_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/program_ram.sv
// 1-write/1-read synchronous RAM holding the program image; no reset on the array.
module program_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read data only moves on an accepted read, so it holds between fetches
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/program_memory.sv
// Instruction memory with a RUN/LOAD controller: fetches are served at latency 1 in RUN,
// replaced by NOP_WORD while a program load is in progress.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(PM_NOP_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    pm_state_e         state, state_nx;
    logic [ADDR_W-1:0] wptr, wptr_nx;
    logic [ADDR_W:0]   count_nx;
    logic              done_nx;
    logic              we;
    logic              re;
    logic              out_nop, out_nop_nx;
    logic [DATA_W-1:0] ram_rdata;

    program_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .wdata (load_data),
        .re    (re),
        .raddr (fetch_addr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            wptr        <= '0;
            load_done   <= 1'b0;
            load_count  <= '0;
            fetch_valid <= 1'b0;
            out_nop     <= 1'b1;
        end else begin
            state       <= state_nx;
            wptr        <= wptr_nx;
            load_done   <= done_nx;
            load_count  <= count_nx;
            fetch_valid <= fetch_req;
            out_nop     <= out_nop_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wptr_nx  = wptr;
        done_nx  = 1'b0;
        count_nx = load_count;
        we       = 1'b0;
        case (state)
            ST_RUN: begin
                if (load_start) begin
                    state_nx = ST_LOAD;
                    wptr_nx  = '0;
                end
            end
            ST_LOAD: begin
                // A restart wins over a same-cycle write
                if (load_start) begin
                    wptr_nx = '0;
                end else if (load_valid) begin
                    we      = 1'b1;
                    wptr_nx = wptr + 1'b1;
                    if (load_last || (&wptr)) begin
                        state_nx = ST_RUN;
                        done_nx  = 1'b1;
                        count_nx = {1'b0, wptr} + 1'b1;
                    end
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    // Fetches that collide with a load are answered with NOP_WORD instead of stalling
    always_comb begin
        re         = fetch_req && (state == ST_RUN) && !load_start;
        out_nop_nx = out_nop;
        if (fetch_req) out_nop_nx = !re;
    end

    assign fetch_instr = out_nop ? NOP_WORD : ram_rdata;
    assign load_ready  = (state == ST_LOAD);
    assign busy        = (state != ST_RUN);

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, the fetch/load address width.
REQ-002 SHALL have parameter DATA_W, default 32, the instruction word width.
REQ-003 SHALL have parameter NOP_WORD, default 0 (ADD reg0,reg0,reg0), the word returned on a dropped fetch.
REQ-004 SHALL derive DEPTH = 2**ADDR_W words.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port fetch_req  input  1  fetch request.
REQ-008 SHALL have port fetch_addr  input  ADDR_W  fetch word address.
REQ-009 SHALL have port fetch_valid  output  1  fetch_instr valid this cycle.
REQ-010 SHALL have port fetch_instr  output  DATA_W  fetched word.
REQ-011 SHALL have port load_start  input  1  begin program load.
REQ-012 SHALL have port load_valid  input  1  load_data valid.
REQ-013 SHALL have port load_last  input  1  marks the final load word.
REQ-014 SHALL have port load_data  input  DATA_W  word to write.
REQ-015 SHALL have port load_ready  output  1  block accepts load words.
REQ-016 SHALL have port load_done  output  1  one-cycle pulse at load end.
REQ-017 SHALL have port load_count  output  ADDR_W+1  words written by the last completed load.
REQ-018 SHALL have port busy  output  1  high when the state is not RUN.

Function
REQ-019 SHALL implement a FSM with states RUN and LOAD.
REQ-020 In RUN, fetch_req=1 SHALL give fetch_valid=1 and fetch_instr=mem[fetch_addr] on the next cycle (latency 1); otherwise fetch_valid=0 and fetch_instr holds its value.
REQ-021 Back-to-back fetch_req SHALL sustain one result per cycle.
REQ-022 In RUN, load_start=1 SHALL move the FSM to LOAD and clear the write pointer to 0; a fetch_req in the same cycle SHALL be dropped, giving fetch_valid=1 with fetch_instr=NOP_WORD next cycle.
REQ-023 In LOAD, fetch_req SHALL be dropped the same way (fetch_valid=1, fetch_instr=NOP_WORD), so the pipeline never stalls on a request.
REQ-024 load_ready SHALL equal (state==LOAD).
REQ-025 Each cycle with load_valid & load_ready SHALL write load_data to mem[wptr] and increment wptr.
REQ-026 A write with load_last=1, or a write to address DEPTH-1, SHALL end the load: return to RUN next cycle, pulse load_done for one cycle, and set load_count = words written (1..DEPTH).
REQ-027 load_start while in LOAD SHALL restart the load: wptr=0, no write that cycle, words already written remain.
REQ-028 load_valid outside LOAD SHALL be ignored, with no write.
REQ-029 Words not written by a load SHALL keep their previous contents.
REQ-030 A load abandoned by reset SHALL leave written words in memory, set state to RUN and leave load_count unchanged from reset value.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state=RUN, wptr=0, fetch_valid=0, fetch_instr=NOP_WORD, load_done=0, load_count=0 and busy=0.
REQ-032 Memory array contents SHALL NOT be affected by reset.
REQ-033 Reset release SHALL be usable on any edge; the first fetch_req after release SHALL be serviced normally.

Structure
REQ-034 The state enum and the NOP_WORD default SHALL live in the shared processor package.
REQ-035 The storage array SHALL be one sub-module, program_ram: a 1-write/1-read synchronous RAM with DEPTH x DATA_W. The FSM, pointer and output registers SHALL stay in program_memory.

Verification
REQ-036 Reset, fetch addr 0 -> fetch_valid=0 during reset. After release, fetch_req addr 3 with mem[3]=0x1334_0005 -> next cycle fetch_valid=1, fetch_instr=0x1334_0005.
REQ-037 Load 3 words 0xA,0xB,0xC, last on 0xC -> load_done pulse, load_count=3, busy low. Fetch 0,1,2 back-to-back -> 0xA,0xB,0xC on consecutive cycles. Fetch 3 returns its pre-load value.
REQ-038 Full load of 32 words with load_last never asserted -> load ends after the write to addr 31, load_count=32.
REQ-039 fetch_req together with load_start, then during LOAD -> fetch_valid=1 with NOP_WORD each cycle, and no memory corruption.
REQ-040 load_start mid-load after 2 words, then 1 word with last -> mem[0] holds the new word, mem[1] the earlier word, load_count=1.
REQ-041 rst_n asserted mid-load after 4 words -> state RUN, load_count=0, mem[0..3] hold the loaded words.
